bp_be_scoreboard: RTL and testbench
===================================

Name: bp_be_scoreboard

Overview:
- Parametrised register scoreboard that replaces the single-issue hazard check inside the checker.
- Tracks in-flight destination registers and raises RAW, WAW and structural hazards for a configurable number of source operands.
- Fixed-latency writes retire via per-register countdowns. Variable-latency writes (divide, FP divide/sqrt, cache/TLB miss) retire on an explicit writeback.
- Flush squashes only uncommitted writes. One instance per register file (integer and FP).

Parameters:
- num_regs_p, 32, architectural registers tracked.
- num_rs_p, 3, source operand ports checked per dispatch.
- max_lat_p, 7, largest fixed latency accepted on rd_lat_i.
- commit_lat_p, 3, cycles after dispatch until a write is committed (non-squashable).
- max_long_p, 4, maximum outstanding variable-latency writes.
- zero_reg_p, 1, when 1, register 0 is never marked busy and never hazards.
- Derived: addr_w = $clog2(num_regs_p), lat_w = $clog2(max_lat_p+1), cmt_w = $clog2(commit_lat_p+1), cnt_w = $clog2(max_long_p+1).

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  asynchronous active-low reset
- dispatch_v_i  in  1  instruction issued this cycle
- rd_w_v_i  in  1  issuing instruction writes rd
- rd_addr_i  in  addr_w  destination register
- rd_long_i  in  1  write is variable-latency
- rd_lat_i  in  lat_w  fixed latency in cycles (ignored when rd_long_i)
- rs_v_i  in  num_rs_p  source operand valid
- rs_addr_i  in  num_rs_p*addr_w  packed source addresses, port 0 in LSBs
- wb_v_i  in  1  variable-latency writeback
- wb_addr_i  in  addr_w  writeback register
- flush_i  in  1  squash uncommitted writes
- rs_hazard_o  out  num_rs_p  per-operand RAW hazard
- waw_hazard_o  out  1  destination conflict
- struct_hazard_o  out  1  long-op table full and incoming op is long
- hazard_o  out  1  OR of all hazards
- long_cnt_o  out  cnt_w  outstanding variable-latency writes

Behaviour:
- Per-register state:
  - lat_r: cycles until the result can be forwarded; 0 = not busy.
  - long_r: variable-latency write pending.
  - cmt_r: cycles until committed; 0 = committed.
- Reset (asynchronous, reset_n_i low): all lat_r, long_r, cmt_r and long_cnt cleared. All outputs 0 while in reset.
- A dispatch is "tracked" when dispatch_v_i & rd_w_v_i & ~(zero_reg_p & rd_addr_i==0) & ~flush_i.
- Tracked dispatch loads the rd entry at the next edge:
  - cmt_r = commit_lat_p.
  - If rd_long_i: long_r = 1, long_cnt +1.
  - Otherwise: lat_r = rd_lat_i. rd_lat_i==0 means the result is bypassable next cycle, so nothing is marked busy.
- Every cycle, each nonzero lat_r and cmt_r decrements by 1. A load of the same entry in that cycle wins over the decrement.
- wb_v_i clears long_r[wb_addr_i] and decrements long_cnt.
  - wb on a register with long_r==0 is an error; an assertion fires and state is unchanged.
- wb and long dispatch in the same cycle:
  - Same register: the dispatch value wins.
  - long_cnt nets to an unchanged value.
- flush_i clears every entry with cmt_r!=0 (lat_r, long_r, cmt_r). long_cnt is reduced by the popcount of cleared long_r bits plus any simultaneous wb. A dispatch in the flush cycle is dropped.
- Hazards are combinational from current state and current inputs, with zero latency:
  - rs_hazard_o[i] = rs_v_i[i] & (lat_r[rs]!=0 | long_r[rs]) & ~(zero_reg_p & rs==0).
  - waw_hazard_o = rd_w_v_i & (long_r[rd] | (~rd_long_i & lat_r[rd] > rd_lat_i)). This prevents out-of-order completion onto the same register.
  - struct_hazard_o = rd_w_v_i & rd_long_i & (long_cnt == max_long_p).
- dispatch_v_i asserted while hazard_o=1 is a protocol error: an assertion fires, and the block still applies the update.
- long_cnt saturates at neither bound by construction; overflow or underflow is asserted.
- Parameter checks (elaboration): max_lat_p >= 1, commit_lat_p >= 1, max_long_p >= 1.

Decomposition:
- bp_be_pkg gains:
  - constant bp_be_sb_max_lat (default for max_lat_p).
  - a bp_be_sb_entry_s struct {lat, long, cmt} with its width macro.
- Sub-module bp_be_scoreboard_entry: one register's counters, load, decrement and flush-clear. It is instantiated num_regs_p times.
- The top level handles:
  - address decode;
  - the rs/rd read muxes;
  - the long counter;
  - assertions.

Test Plan:
- Reset: drive reset_n_i low mid-stream with 3 regs busy -> all outputs 0 immediately; after release, rs x5 queried -> no hazard.
- Fixed latency: dispatch rd=x5, lat=3, then query rs0=x5 each cycle -> rs_hazard_o[0]=1 for 3 cycles, then 0; query x0 with zero_reg_p=1 -> never hazards.
- WAW ordering: x7 lat=5 in flight, second dispatch rd=x7 lat=2 -> waw_hazard_o=1; the same dispatch with lat=6 -> waw_hazard_o=0.
- Long ops: 4 long dispatches to x1..x4 -> long_cnt_o=4; a 5th long op -> struct_hazard_o=1; wb x2 and long dispatch to x9 in the same cycle -> long_cnt_o stays 4, x2 clear, x9 busy.
- Flush: dispatch x10 lat=6 and long x11, wait 1 cycle, flush -> both cleared and long_cnt decremented; an entry older than commit_lat_p survives.
- Multi-port: rs_v=3'b101 with rs0=x5 busy, rs1=x5, rs2=x6 free -> rs_hazard_o=3'b001, hazard_o=1.

Source files
------------

// File: rtl/bp_be_pkg.sv
// Shared back-end definitions.
//   bp_be_sb_max_lat     : default largest fixed latency tracked by the scoreboard
//   bp_be_sb_commit_lat  : default cycles from dispatch until a write is committed
//   bp_be_sb_entry_s     : per-register scoreboard state {lat, long_v, cmt} at default widths
//   BP_BE_SB_ENTRY_WIDTH : width of one scoreboard entry for given lat/cmt widths
package bp_be_pkg;

  localparam int bp_be_sb_max_lat    = 7;
  localparam int bp_be_sb_commit_lat = 3;
  localparam int bp_be_sb_lat_w      = $clog2(bp_be_sb_max_lat + 1);
  localparam int bp_be_sb_cmt_w      = $clog2(bp_be_sb_commit_lat + 1);

  typedef struct packed {
    logic [bp_be_sb_lat_w-1:0] lat;     // cycles until forwardable, 0 = not busy
    logic                      long_v;  // variable-latency write pending
    logic [bp_be_sb_cmt_w-1:0] cmt;     // cycles until committed, 0 = committed
  } bp_be_sb_entry_s;

endpackage

`define BP_BE_SB_ENTRY_WIDTH(lat_w_mp, cmt_w_mp) ((lat_w_mp) + 1 + (cmt_w_mp))

// File: rtl/bp_be_scoreboard_entry.sv
// One architectural register's scoreboard state.
//   clk_i, reset_n_i : clock, asynchronous active-low reset
//   load_i           : tracked dispatch targets this register
//   load_long_i      : the dispatched write is variable-latency
//   load_lat_i       : fixed latency of the dispatched write
//   wb_clr_i         : variable-latency writeback to this register
//   flush_i          : squash the entry if it is not yet committed
//   lat_o, long_o, cmt_o : current state
module bp_be_scoreboard_entry
  import bp_be_pkg::*;
#(
  parameter int lat_w_p      = bp_be_sb_lat_w,
  parameter int cmt_w_p      = bp_be_sb_cmt_w,
  parameter int commit_lat_p = bp_be_sb_commit_lat
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               load_i,
  input  logic               load_long_i,
  input  logic [lat_w_p-1:0] load_lat_i,
  input  logic               wb_clr_i,
  input  logic               flush_i,
  output logic [lat_w_p-1:0] lat_o,
  output logic               long_o,
  output logic [cmt_w_p-1:0] cmt_o
);

  typedef struct packed {
    logic [lat_w_p-1:0] lat;
    logic               long_v;
    logic [cmt_w_p-1:0] cmt;
  } entry_s;

  if ($bits(entry_s) != `BP_BE_SB_ENTRY_WIDTH(lat_w_p, cmt_w_p)) begin : g_bad_entry_w
    $error("scoreboard entry layout does not match BP_BE_SB_ENTRY_WIDTH");
  end

  entry_s entry_q, entry_d;

  always_comb begin
    entry_d = entry_q;
    if (entry_q.lat != '0) entry_d.lat = entry_q.lat - lat_w_p'(1);
    if (entry_q.cmt != '0) entry_d.cmt = entry_q.cmt - cmt_w_p'(1);
    if (wb_clr_i) entry_d.long_v = 1'b0;
    // A new dispatch overrides both the countdown and a same-cycle writeback.
    if (load_i) begin
      entry_d.cmt = cmt_w_p'(commit_lat_p);
      if (load_long_i) entry_d.long_v = 1'b1;
      else             entry_d.lat    = load_lat_i;
    end
    // Committed writes survive a flush; the top never loads during a flush.
    if (flush_i && (entry_q.cmt != '0)) entry_d = '0;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) entry_q <= '0;
    else            entry_q <= entry_d;
  end

  assign lat_o  = entry_q.lat;
  assign long_o = entry_q.long_v;
  assign cmt_o  = entry_q.cmt;

endmodule

// File: rtl/bp_be_scoreboard.sv
// Register scoreboard: tracks in-flight destination registers and reports
// RAW, WAW and structural hazards for the instruction being dispatched.
//   clk_i, reset_n_i      : clock, asynchronous active-low reset
//   dispatch_v_i          : instruction issued this cycle
//   rd_w_v_i, rd_addr_i   : issuing instruction writes rd
//   rd_long_i, rd_lat_i   : variable-latency flag / fixed latency
//   rs_v_i, rs_addr_i     : source operands (port 0 in LSBs)
//   wb_v_i, wb_addr_i     : variable-latency writeback
//   flush_i               : squash uncommitted writes
//   rs_hazard_o           : per-operand RAW hazard
//   waw_hazard_o          : destination conflict
//   struct_hazard_o       : long-op table full and incoming op is long
//   hazard_o              : OR of all hazards
//   long_cnt_o            : outstanding variable-latency writes
module bp_be_scoreboard
  import bp_be_pkg::*;
#(
  parameter  int num_regs_p   = 32,
  parameter  int num_rs_p     = 3,
  parameter  int max_lat_p    = bp_be_sb_max_lat,
  parameter  int commit_lat_p = bp_be_sb_commit_lat,
  parameter  int max_long_p   = 4,
  parameter  int zero_reg_p   = 1,
  localparam int addr_w       = $clog2(num_regs_p),
  localparam int lat_w        = $clog2(max_lat_p + 1),
  localparam int cmt_w        = $clog2(commit_lat_p + 1),
  localparam int cnt_w        = $clog2(max_long_p + 1)
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       dispatch_v_i,
  input  logic                       rd_w_v_i,
  input  logic [addr_w-1:0]          rd_addr_i,
  input  logic                       rd_long_i,
  input  logic [lat_w-1:0]           rd_lat_i,
  input  logic [num_rs_p-1:0]        rs_v_i,
  input  logic [num_rs_p*addr_w-1:0] rs_addr_i,
  input  logic                       wb_v_i,
  input  logic [addr_w-1:0]          wb_addr_i,
  input  logic                       flush_i,
  output logic [num_rs_p-1:0]        rs_hazard_o,
  output logic                       waw_hazard_o,
  output logic                       struct_hazard_o,
  output logic                       hazard_o,
  output logic [cnt_w-1:0]           long_cnt_o
);

  if (max_lat_p < 1) begin : g_bad_max_lat
    $error("max_lat_p must be >= 1");
  end
  if (commit_lat_p < 1) begin : g_bad_commit_lat
    $error("commit_lat_p must be >= 1");
  end
  if (max_long_p < 1) begin : g_bad_max_long
    $error("max_long_p must be >= 1");
  end

  localparam bit zero_on = (zero_reg_p != 0);

  logic [lat_w-1:0]      lat_r [num_regs_p];
  logic [cmt_w-1:0]      cmt_r [num_regs_p];
  logic [num_regs_p-1:0] long_r;
  logic [num_regs_p-1:0] load_sel, wb_sel, long_clr;
  logic                  tracked, wb_hit;
  logic [cnt_w-1:0]      long_cnt_q, long_cnt_d;
  logic [addr_w-1:0]     rs_a;
  int                    clr_n;
  int                    cnt_next;

  assign tracked = dispatch_v_i & rd_w_v_i & ~(zero_on && (rd_addr_i == '0)) & ~flush_i;
  // A writeback to a register with nothing pending is ignored.
  assign wb_hit  = wb_v_i & long_r[wb_addr_i];

  for (genvar g = 0; g < num_regs_p; g++) begin : g_entry
    assign load_sel[g] = tracked && (rd_addr_i == addr_w'(g));
    assign wb_sel[g]   = wb_hit && (wb_addr_i == addr_w'(g));
    // Every long bit dropped this cycle, whether by writeback or flush; a
    // same-cycle reload is added back through the increment below.
    assign long_clr[g] = long_r[g] & (wb_sel[g] | (flush_i & (cmt_r[g] != '0)));

    bp_be_scoreboard_entry #(
      .lat_w_p      (lat_w),
      .cmt_w_p      (cmt_w),
      .commit_lat_p (commit_lat_p)
    ) u_entry (
      .clk_i       (clk_i),
      .reset_n_i   (reset_n_i),
      .load_i      (load_sel[g]),
      .load_long_i (rd_long_i),
      .load_lat_i  (rd_lat_i),
      .wb_clr_i    (wb_sel[g]),
      .flush_i     (flush_i),
      .lat_o       (lat_r[g]),
      .long_o      (long_r[g]),
      .cmt_o       (cmt_r[g])
    );
  end

  always_comb begin
    clr_n = 0;
    for (int i = 0; i < num_regs_p; i++) clr_n = clr_n + int'(long_clr[i]);
    cnt_next   = int'(long_cnt_q) + int'(tracked & rd_long_i) - clr_n;
    long_cnt_d = cnt_w'(cnt_next);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) long_cnt_q <= '0;
    else            long_cnt_q <= long_cnt_d;
  end

  always_comb begin
    rs_hazard_o = '0;
    rs_a        = '0;
    for (int i = 0; i < num_rs_p; i++) begin
      rs_a           = rs_addr_i[i*addr_w +: addr_w];
      rs_hazard_o[i] = rs_v_i[i] & ((lat_r[rs_a] != '0) | long_r[rs_a])
                       & ~(zero_on && (rs_a == '0));
    end
  end

  // A fixed write may not finish before an older write to the same register.
  assign waw_hazard_o    = rd_w_v_i & (long_r[rd_addr_i]
                           | (~rd_long_i & (lat_r[rd_addr_i] > rd_lat_i)));
  assign struct_hazard_o = rd_w_v_i & rd_long_i & (long_cnt_q == cnt_w'(max_long_p));
  assign hazard_o        = (|rs_hazard_o) | waw_hazard_o | struct_hazard_o;
  assign long_cnt_o      = long_cnt_q;

`ifndef SYNTHESIS
  a_wb_pending: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    wb_v_i |-> long_r[wb_addr_i]);
  a_dispatch_no_hazard: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    dispatch_v_i |-> !hazard_o);
  a_long_cnt_range: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    (cnt_next >= 0) && (cnt_next <= max_long_p));
`endif

endmodule

// File: tb/tb_bp_be_scoreboard.sv
module tb_bp_be_scoreboard;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        dispatch_v, rd_w_v, rd_long, wb_v, flush;
  logic [4:0]  rd_addr, wb_addr;
  logic [2:0]  rd_lat, rs_v;
  logic [14:0] rs_addr;
  logic [2:0]  rs_hazard;
  logic        waw, strh, haz;
  logic [2:0]  long_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bp_be_scoreboard dut (
    .clk_i           (clk),
    .reset_n_i       (reset_n),
    .dispatch_v_i    (dispatch_v),
    .rd_w_v_i        (rd_w_v),
    .rd_addr_i       (rd_addr),
    .rd_long_i       (rd_long),
    .rd_lat_i        (rd_lat),
    .rs_v_i          (rs_v),
    .rs_addr_i       (rs_addr),
    .wb_v_i          (wb_v),
    .wb_addr_i       (wb_addr),
    .flush_i         (flush),
    .rs_hazard_o     (rs_hazard),
    .waw_hazard_o    (waw),
    .struct_hazard_o (strh),
    .hazard_o        (haz),
    .long_cnt_o      (long_cnt)
  );

  // Reference model: absolute cycle numbers at which a register becomes
  // forwardable / committed, plus the set of registers awaiting writeback.
  int ready_c [32];
  int cmt_c   [32];
  bit lng     [32];
  int mcyc = 0;

  function automatic void m_clear();
    for (int r = 0; r < 32; r++) begin
      ready_c[r] = 0; cmt_c[r] = 0; lng[r] = 1'b0;
    end
  endfunction

  function automatic int m_cnt();
    int n = 0;
    for (int r = 0; r < 32; r++) if (lng[r]) n++;
    return n;
  endfunction

  // Packed view: {rs_hazard[2:0], waw, struct, hazard, long_cnt[2:0]}
  function automatic logic [8:0] pk(bit [2:0] rs, bit w, bit s, bit h, int c);
    return {rs, w, s, h, 3'(c)};
  endfunction

  function automatic logic [8:0] outs();
    return {rs_hazard, waw, strh, haz, long_cnt};
  endfunction

  function automatic logic [8:0] m_outs();
    logic [2:0] rsh;
    logic w, s;
    int a, rd;
    for (int i = 0; i < 3; i++) begin
      a = int'(rs_addr[i*5 +: 5]);
      rsh[i] = rs_v[i] && (a != 0) && ((ready_c[a] > mcyc) || lng[a]);
    end
    rd = int'(rd_addr);
    w = rd_w_v && (lng[rd] || (!rd_long && ((ready_c[rd] - mcyc) > int'(rd_lat))));
    s = rd_w_v && rd_long && (m_cnt() == 4);
    return {rsh, w, s, (|rsh) || w || s, 3'(m_cnt())};
  endfunction

  // Advance the model across the coming clock edge using the current inputs.
  function automatic void m_step();
    int rd = int'(rd_addr);
    if (!reset_n) begin
      m_clear();
    end else begin
      if (wb_v) lng[int'(wb_addr)] = 1'b0;
      if (flush)
        for (int r = 0; r < 32; r++)
          if (cmt_c[r] > mcyc) begin
            ready_c[r] = 0; cmt_c[r] = 0; lng[r] = 1'b0;
          end
      if (dispatch_v && rd_w_v && (rd != 0) && !flush) begin
        cmt_c[rd] = mcyc + 1 + 3;
        if (rd_long) lng[rd] = 1'b1;
        else         ready_c[rd] = mcyc + 1 + int'(rd_lat);
      end
    end
    mcyc++;
  endfunction

  task automatic check(string name, logic [8:0] act, logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got {rs,waw,str,haz,cnt}=%b required %b", name, act, exp);
    end
  endtask

  task automatic cycle();
    m_step();
    @(negedge clk);
  endtask

  task automatic drive(bit d, bit rdw, int rd, bit lg, int lat, bit [2:0] rsv,
                       int r0, int r1, int r2, bit wb, int wba, bit fl);
    dispatch_v = d;  rd_w_v = rdw;  rd_addr = 5'(rd);  rd_long = lg;
    rd_lat = 3'(lat); rs_v = rsv;   rs_addr = {5'(r2), 5'(r1), 5'(r0)};
    wb_v = wb;       wb_addr = 5'(wba); flush = fl;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    idle();
    m_clear();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  typedef struct {
    bit d, rdw; int rd; bit lg; int lat;
    bit [2:0] rsv; int r0, r1, r2;
    bit wb; int wba;
    logic [8:0] exp;
  } vec_t;

  function automatic vec_t mk(bit d, bit rdw, int rd, bit lg, int lat, bit [2:0] rsv,
                              int r0, int r1, int r2, bit wb, int wba,
                              bit [2:0] ers, bit ew, bit es, bit eh, int ec);
    vec_t v;
    v.d = d; v.rdw = rdw; v.rd = rd; v.lg = lg; v.lat = lat;
    v.rsv = rsv; v.r0 = r0; v.r1 = r1; v.r2 = r2; v.wb = wb; v.wba = wba;
    v.exp = pk(ers, ew, es, eh, ec);
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [20];
    int wb_pick;

    // fixed latency x5=3, zero register, WAW ordering, multi-port, one long op
    tbl[0]  = mk(1,1,5,0,3, 3'b000,0,0,0, 0,0, 3'b000,0,0,0,0);
    tbl[1]  = mk(0,0,0,0,0, 3'b001,5,0,0, 0,0, 3'b001,0,0,1,0);
    tbl[2]  = mk(0,0,0,0,0, 3'b001,5,0,0, 0,0, 3'b001,0,0,1,0);
    tbl[3]  = mk(0,0,0,0,0, 3'b001,5,0,0, 0,0, 3'b001,0,0,1,0);
    tbl[4]  = mk(0,0,0,0,0, 3'b001,5,0,0, 0,0, 3'b000,0,0,0,0);
    tbl[5]  = mk(1,1,0,0,5, 3'b001,0,0,0, 0,0, 3'b000,0,0,0,0);
    tbl[6]  = mk(0,0,0,0,0, 3'b001,0,0,0, 0,0, 3'b000,0,0,0,0);
    tbl[7]  = mk(1,1,7,0,5, 3'b000,0,0,0, 0,0, 3'b000,0,0,0,0);
    tbl[8]  = mk(0,1,7,0,2, 3'b000,0,0,0, 0,0, 3'b000,1,0,1,0);
    tbl[9]  = mk(0,1,7,0,6, 3'b000,0,0,0, 0,0, 3'b000,0,0,0,0);
    tbl[10] = mk(0,1,7,0,3, 3'b000,0,0,0, 0,0, 3'b000,0,0,0,0);
    tbl[11] = mk(0,1,7,0,1, 3'b000,0,0,0, 0,0, 3'b000,1,0,1,0);
    tbl[12] = mk(1,1,5,0,2, 3'b000,0,0,0, 0,0, 3'b000,0,0,0,0);
    tbl[13] = mk(0,0,0,0,0, 3'b101,5,5,6, 0,0, 3'b001,0,0,1,0);
    tbl[14] = mk(0,0,0,0,0, 3'b111,6,5,5, 0,0, 3'b110,0,0,1,0);
    tbl[15] = mk(0,0,0,0,0, 3'b111,5,5,5, 0,0, 3'b000,0,0,0,0);
    tbl[16] = mk(1,1,3,1,0, 3'b000,0,0,0, 0,0, 3'b000,0,0,0,0);
    tbl[17] = mk(0,1,3,0,0, 3'b001,3,0,0, 0,0, 3'b001,1,0,1,1);
    tbl[18] = mk(0,0,0,0,0, 3'b001,3,0,0, 1,3, 3'b001,0,0,1,1);
    tbl[19] = mk(0,0,0,0,0, 3'b001,3,0,0, 0,0, 3'b000,0,0,0,0);

    reset_n = 1'b0;
    idle();
    m_clear();
    @(negedge clk);
    #1 check("reset_state", outs(), pk(3'b000,0,0,0,0));
    @(negedge clk);
    reset_n = 1'b1;

    for (int k = 0; k < 20; k++) begin
      drive(tbl[k].d, tbl[k].rdw, tbl[k].rd, tbl[k].lg, tbl[k].lat, tbl[k].rsv,
            tbl[k].r0, tbl[k].r1, tbl[k].r2, tbl[k].wb, tbl[k].wba, 0);
      #1 check($sformatf("vec%0d", k), outs(), tbl[k].exp);
      cycle();
    end

    // Long ops: fill the table, structural hazard, wb + long dispatch together
    do_reset();
    for (int r = 1; r <= 4; r++) begin
      drive(1,1,r,1,0, 3'b000,0,0,0, 0,0, 0);
      #1 check($sformatf("long_fill%0d", r), outs(), pk(3'b000,0,0,0,r-1));
      cycle();
    end
    drive(0,1,8,1,0, 3'b000,0,0,0, 0,0, 0);
    #1 check("long_struct_full", outs(), pk(3'b000,0,1,1,4));
    cycle();
    drive(0,0,0,0,0, 3'b000,0,0,0, 1,4, 0);
    #1 check("long_wb_x4", outs(), pk(3'b000,0,0,0,4));
    cycle();
    drive(1,1,9,1,0, 3'b000,0,0,0, 1,2, 0);
    #1 check("long_wb_and_disp", outs(), pk(3'b000,0,0,0,3));
    cycle();
    drive(0,0,0,0,0, 3'b111,2,9,1, 0,0, 0);
    #1 check("long_after_swap", outs(), pk(3'b110,0,0,1,3));
    cycle();

    // Flush: only uncommitted writes go; a dispatch in the flush cycle is dropped
    do_reset();
    drive(1,1,12,1,0, 3'b000,0,0,0, 0,0, 0); cycle();
    idle(); cycle(); cycle();
    drive(1,1,13,0,7, 3'b000,0,0,0, 0,0, 0); cycle();
    idle(); cycle();
    drive(1,1,10,0,6, 3'b000,0,0,0, 0,0, 0); cycle();
    drive(1,1,11,1,0, 3'b000,0,0,0, 0,0, 0); cycle();
    drive(0,0,0,0,0, 3'b111,10,11,12, 0,0, 0);
    #1 check("flush_pre_busy", outs(), pk(3'b111,0,0,1,2));
    cycle();
    drive(1,1,14,0,5, 3'b000,0,0,0, 0,0, 1);
    #1 check("flush_cycle", outs(), pk(3'b000,0,0,0,2));
    cycle();
    drive(0,0,0,0,0, 3'b111,12,13,10, 0,0, 0);
    #1 check("flush_survivors", outs(), pk(3'b011,0,0,1,1));
    cycle();
    drive(0,0,0,0,0, 3'b111,11,14,12, 0,0, 0);
    #1 check("flush_dropped", outs(), pk(3'b100,0,0,1,1));
    cycle();

    // Asynchronous reset mid-stream with three registers busy
    do_reset();
    drive(1,1,5,0,7, 3'b000,0,0,0, 0,0, 0); cycle();
    drive(1,1,6,0,7, 3'b000,0,0,0, 0,0, 0); cycle();
    drive(1,1,7,1,0, 3'b000,0,0,0, 0,0, 0); cycle();
    drive(0,1,7,1,0, 3'b111,5,6,7, 0,0, 0);
    #1 check("reset_pre", outs(), pk(3'b111,1,0,1,1));
    reset_n = 1'b0;
    m_clear();
    #1 check("reset_async", outs(), pk(3'b000,0,0,0,0));
    cycle();
    reset_n = 1'b1;
    drive(0,0,0,0,0, 3'b111,5,6,7, 0,0, 0);
    #1 check("reset_release", outs(), pk(3'b000,0,0,0,0));
    cycle();

    // Randomized, legal traffic against the reference model
    do_reset();
    for (int n = 0; n < 800; n++) begin
      dispatch_v = 1'($urandom_range(0, 1));
      rd_w_v     = ($urandom_range(0, 3) != 0);
      rd_addr    = 5'($urandom_range(0, 15));
      rd_long    = ($urandom_range(0, 3) == 0);
      rd_lat     = 3'($urandom_range(0, 7));
      rs_v       = 3'($urandom_range(0, 7));
      rs_addr    = {5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)),
                    5'($urandom_range(0, 15))};
      flush      = ($urandom_range(0, 23) == 0);
      wb_v       = 1'b0;
      wb_addr    = '0;
      if ((m_cnt() > 0) && ($urandom_range(0, 2) == 0)) begin
        wb_pick = $urandom_range(0, 31);
        for (int k = 0; k < 32; k++)
          if (!wb_v && lng[(wb_pick + k) % 32]) begin
            wb_v    = 1'b1;
            wb_addr = 5'((wb_pick + k) % 32);
          end
      end
      if (m_outs()[3]) dispatch_v = 1'b0;
      #1 check($sformatf("rand%0d", n), outs(), m_outs());
      cycle();
    end

    idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
